fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/rv_pkg.sv | 28 ++
 rtl/fetch_stage_pc_reg.sv | 27 ++
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 constants for the front end: word width, NOP encoding, major
// opcodes and the fetch-stage state encoding.
package rv_pkg;

    localparam int          XLEN = 32;
    localparam logic [31:0] NOP  = 32'h0000_0013;   // addi x0, x0, 0

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_IMM    = 7'd19;
    localparam logic [6:0] OP_AUIPC  = 7'd23;
    localparam logic [6:0] OP_REG    = 7'd51;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JALR   = 7'd103;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_WAIT  = 3'd1,
        S_FULL  = 3'd2,
        S_DRAIN = 3'd3,
        S_HALT  = 3'd4
    } fetch_state_t;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: asynchronous reset to RESET_PC, load has priority
// over the +4 increment, which wraps modulo 2^XLEN.
module pc_reg #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [XLEN-1:0] load_val,
    input  logic            inc,
    output logic [XLEN-1:0] pc
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + XLEN'(4);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem read, one-entry output buffer,
// redirect flushing. Optional macro FETCH_ALIGN_CHECK_EN halts on misaligned redirects.
module fetch_stage
    import rv_pkg::*;
#(
    parameter int               XLEN     = rv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(32'h0000_0000)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCsrc,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            fetch_misalign
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            misalign_target;
    logic            pc_load, pc_inc, req, capture, clear;

`ifdef FETCH_ALIGN_CHECK_EN
    assign target          = branch_target;
    assign misalign_target = |branch_target[1:0];
`else
    assign target          = branch_target & ~XLEN'(3);
    assign misalign_target = 1'b0;
`endif

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load),
        .load_val (target),
        .inc      (pc_inc),
        .pc       (pc)
    );

    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        req     = 1'b0;
        capture = 1'b0;
        clear   = 1'b0;
        if (state_q != S_HALT && PCsrc) begin
            clear = 1'b1;
            if (misalign_target) begin
                state_d = S_HALT;
            end else begin
                pc_load = 1'b1;
                // A read still in flight must be swallowed before refetching.
                case (state_q)
                    S_WAIT, S_DRAIN: state_d = imem_rvalid ? S_FETCH : S_DRAIN;
                    default:         state_d = S_FETCH;
                endcase
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    req     = 1'b1;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        capture = 1'b1;
                        pc_inc  = 1'b1;
                        state_d = S_FULL;
                    end
                end
                S_FULL: begin
                    if (instr_valid && instr_ready) begin
                        clear   = 1'b1;
                        req     = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) state_d = S_FETCH;
                end
                default: state_d = S_HALT;
            endcase
        end
    end

    // Gated with rst_n so no request leaks out while reset is held.
    assign imem_req  = req & rst_n;
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            instr_valid <= 1'b0;
            instr_o     <= XLEN'(NOP);
            pc_o        <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (capture) begin
                instr_valid <= 1'b1;
                instr_o     <= imem_rdata;
                pc_o        <= pc;
            end else if (clear) begin
                instr_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_misalign <= 1'b0;
        end else if (state_q != S_HALT && PCsrc && misalign_target) begin
            fetch_misalign <= 1'b1;
        end
    end
`else
    assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a latency-programmable
// instruction memory model driven from the stimulus tasks.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCsrc;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        fetch_misalign;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mem_lat  = 1;
    bit pend     = 1'b0;
    int pend_cnt = 0;
    logic [31:0] pend_addr = '0;

    logic [31:0] req_addr_q[$];
    int          req_cyc_q[$];
    logic [31:0] cons_instr_q[$];
    logic [31:0] cons_pc_q[$];
    logic [31:0] seen_pc_q[$];

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .PCsrc          (PCsrc),
        .branch_target  (branch_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_o        (instr_o),
        .pc_o           (pc_o),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // One clock: log requests/handshakes, cross the edge, then run the memory model.
    task automatic tick();
        logic        rq;
        logic [31:0] ra;
        #2;
        rq = imem_req;
        ra = imem_addr;
        if (rq) begin
            req_addr_q.push_back(ra);
            req_cyc_q.push_back(cyc);
        end
        if (instr_valid) seen_pc_q.push_back(pc_o);
        if (instr_valid && instr_ready) begin
            cons_instr_q.push_back(instr_o);
            cons_pc_q.push_back(pc_o);
        end
        @(posedge clk);
        #1;
        cyc++;
        imem_rvalid = 1'b0;
        if (rq) begin
            pend      = 1'b1;
            pend_cnt  = mem_lat;
            pend_addr = ra;
        end
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                pend        = 1'b0;
                imem_rvalid = 1'b1;
                imem_rdata  = word_of(pend_addr);
            end
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        PCsrc         = 1'b0;
        branch_target = '0;
        instr_ready   = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = '0;
        pend          = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_addr_q.delete();
        req_cyc_q.delete();
        cons_instr_q.delete();
        cons_pc_q.delete();
        seen_pc_q.delete();
        cyc = 0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        PCsrc         = 1'b0;
        branch_target = '0;
        instr_ready   = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (instr_o !== 32'h0000_0013) begin failures++; $display("FAIL reset_instr: got %h expected 00000013", instr_o); end
        checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc_o: got %h expected 00000000", pc_o); end
        checks++; if (fetch_misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign: got %b expected 0", fetch_misalign); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++; $display("FAIL release_req: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr);
        end
        // Abandon an outstanding read by asserting reset mid-cycle.
        mem_lat = 2;
        cyc = 0;
        tick();
        #3;
        rst_n = 1'b0;
        pend  = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc_o !== 32'h0) begin
            failures++; $display("FAIL midreset_state: got req=%b valid=%b pc_o=%h expected 0 0 00000000", imem_req, instr_valid, pc_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        imem_rvalid = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++; $display("FAIL midreset_refetch: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        mem_lat     = 1;
        instr_ready = 1'b1;
        repeat (6) tick();
        checks++;
        if (req_addr_q.size() != 3) begin
            failures++; $display("FAIL seq_req_count: got %0d expected 3", req_addr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (req_addr_q[i] !== 32'(4 * i) || req_cyc_q[i] != 2 * i) begin
                    failures++;
                    $display("FAIL seq_req%0d: got addr=%h cyc=%0d expected addr=%h cyc=%0d",
                             i, req_addr_q[i], req_cyc_q[i], 32'(4 * i), 2 * i);
                end
            end
        end
        checks++;
        if (cons_pc_q.size() != 2) begin
            failures++; $display("FAIL seq_cons_count: got %0d expected 2", cons_pc_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (cons_pc_q[i] !== 32'(4 * i) || cons_instr_q[i] !== word_of(32'(4 * i))) begin
                    failures++;
                    $display("FAIL seq_cons%0d: got pc=%h instr=%h expected pc=%h instr=%h",
                             i, cons_pc_q[i], cons_instr_q[i], 32'(4 * i), word_of(32'(4 * i)));
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        mem_lat     = 1;
        instr_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
            end
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_o !== word_of(32'h0) || pc_o !== 32'h0 || imem_req !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d: got valid=%b instr=%h pc=%h req=%b expected 1 %h 00000000 0",
                         i, instr_valid, instr_o, pc_o, imem_req, word_of(32'h0));
            end
        end
        checks++; if (req_addr_q.size() != 1) begin failures++; $display("FAIL stall_no_req: got %0d requests expected 1", req_addr_q.size()); end
        instr_ready = 1'b1;
        tick();
        checks++;
        if (req_addr_q.size() != 2 || cons_pc_q.size() != 1) begin
            failures++; $display("FAIL stall_release: got reqs=%0d cons=%0d expected 2 1", req_addr_q.size(), cons_pc_q.size());
        end else if (req_addr_q[1] !== 32'h4 || cons_instr_q[0] !== word_of(32'h0)) begin
            failures++; $display("FAIL stall_release: got addr=%h instr=%h expected 00000004 %h", req_addr_q[1], cons_instr_q[0], word_of(32'h0));
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        mem_lat     = 3;
        instr_ready = 1'b1;
        tick();
        PCsrc         = 1'b1;
        branch_target = 32'h100;
        tick();
        PCsrc = 1'b0;
        repeat (7) tick();
        checks++;
        if (req_addr_q.size() < 2) begin
            failures++; $display("FAIL drain_req_count: got %0d expected at least 2", req_addr_q.size());
        end else if (req_addr_q[1] !== 32'h100 || req_cyc_q[1] != 4) begin
            failures++; $display("FAIL drain_refetch: got addr=%h cyc=%0d expected 00000100 4", req_addr_q[1], req_cyc_q[1]);
        end
        checks++;
        if (seen_pc_q.size() == 0 || seen_pc_q[0] !== 32'h100) begin
            failures++; $display("FAIL drain_dropped: got %0d valid cycles first_pc=%h expected first_pc=00000100",
                                 seen_pc_q.size(), (seen_pc_q.size() == 0) ? 32'hx : seen_pc_q[0]);
        end
        checks++;
        if (cons_pc_q.size() != 1 || cons_instr_q[0] !== word_of(32'h100)) begin
            failures++; $display("FAIL drain_deliver: got cons=%0d expected 1 with instr=%h", cons_pc_q.size(), word_of(32'h100));
        end
    endtask

    task automatic test_redirect_rvalid();
        do_reset();
        mem_lat     = 2;
        instr_ready = 1'b1;
        tick();
        tick();
        PCsrc         = 1'b1;
        branch_target = 32'h200;
        tick();
        PCsrc = 1'b0;
        repeat (4) tick();
        checks++;
        if (req_addr_q.size() < 2 || req_addr_q[1] !== 32'h200 || req_cyc_q[1] != 3) begin
            failures++; $display("FAIL same_cycle_refetch: got reqs=%0d expected addr 00000200 at cycle 3", req_addr_q.size());
        end
        checks++;
        if (cons_pc_q.size() != 1 || cons_pc_q[0] !== 32'h200 || cons_instr_q[0] !== word_of(32'h200)) begin
            failures++; $display("FAIL same_cycle_dropped: got cons=%0d expected single pc 00000200", cons_pc_q.size());
        end
    endtask

    task automatic test_flush_full();
        do_reset();
        mem_lat     = 1;
        instr_ready = 1'b0;
        tick();
        tick();
        PCsrc         = 1'b1;
        branch_target = 32'h40;
        tick();
        PCsrc = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b expected 0", instr_valid); end
        instr_ready = 1'b1;
        tick();
        checks++;
        if (req_addr_q.size() != 2 || req_addr_q[1] !== 32'h40 || req_cyc_q[1] != 3) begin
            failures++; $display("FAIL flush_refetch: got reqs=%0d expected addr 00000040 at cycle 3", req_addr_q.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        mem_lat       = 1;
        instr_ready   = 1'b1;
        PCsrc         = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        PCsrc = 1'b0;
        repeat (3) tick();
        checks++;
        if (req_addr_q.size() != 2) begin
            failures++; $display("FAIL wrap_count: got %0d expected 2", req_addr_q.size());
        end else if (req_addr_q[0] !== 32'hFFFF_FFFC || req_addr_q[1] !== 32'h0 || req_cyc_q[1] != 3) begin
            failures++; $display("FAIL wrap_addr: got %h then %h expected fffffffc then 00000000", req_addr_q[0], req_addr_q[1]);
        end
    endtask

`ifdef FETCH_ALIGN_CHECK_EN
    task automatic test_misalign();
        do_reset();
        mem_lat       = 1;
        instr_ready   = 1'b1;
        PCsrc         = 1'b1;
        branch_target = 32'h102;
        tick();
        PCsrc = 1'b0;
        checks++; if (fetch_misalign !== 1'b1) begin failures++; $display("FAIL misalign_flag: got %b expected 1", fetch_misalign); end
        repeat (5) tick();
        checks++;
        if (req_addr_q.size() != 0 || instr_valid !== 1'b0) begin
            failures++; $display("FAIL misalign_halt: got reqs=%0d valid=%b expected 0 0", req_addr_q.size(), instr_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (fetch_misalign !== 1'b0) begin failures++; $display("FAIL misalign_clear: got %b expected 0", fetch_misalign); end
    endtask
`else
    task automatic test_misalign();
        do_reset();
        mem_lat       = 1;
        instr_ready   = 1'b1;
        PCsrc         = 1'b1;
        branch_target = 32'h102;
        tick();
        PCsrc = 1'b0;
        tick();
        checks++;
        if (req_addr_q.size() != 1 || req_addr_q[0] !== 32'h100 || fetch_misalign !== 1'b0) begin
            failures++; $display("FAIL align_force: got reqs=%0d misalign=%b expected one request to 00000100 and 0",
                                 req_addr_q.size(), fetch_misalign);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_flush_full();
        test_wrap();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
